// File: rtl/elevator_call_scheduler.sv
// Call latching and SCAN-order dispatch for a 3-floor car. Calls are latched per button,
// cleared on door-open service, and a registered target/direction is issued every cycle.
module elevator_call_scheduler (
  input  logic       clk,
  input  logic       rst,
  input  logic       UP1,
  input  logic       UP2,
  input  logic       DOWN2,
  input  logic       DOWN3,
  input  logic       FLOOR1,
  input  logic       FLOOR2,
  input  logic       FLOOR3,
  input  logic [1:0] FS,
  input  logic       door,
  output logic [6:0] lamps,
  output logic       tgt_valid,
  output logic [1:0] tgt_floor,
  output logic [1:0] tgt_dir
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_t;

  state_t     state_r, state_s;
  logic [6:0] calls_r, btn_s, clr_s;
  logic [1:0] cur_floor_r;
  logic       door_q_r;
  logic       service_s, above_fs_s, below_fs_s;
  logic [2:0] dem_s, car_up_s, car_dn_s;
  logic       up_hit_s, dn_hit_s, near_hit_s, use_idle_s;
  logic [1:0] up_flr_s, dn_flr_s, near_flr_s;
  logic       valid_s;
  logic [1:0] floor_s, dir_s;

  assign btn_s     = {FLOOR3, FLOOR2, FLOOR1, DOWN3, DOWN2, UP2, UP1};
  assign service_s = door & ~door_q_r & (FS != 2'd0);

  // Per-floor demand views; index 0..2 maps to floors 1..3.
  assign dem_s    = {calls_r[6] | calls_r[3], calls_r[5] | calls_r[1] | calls_r[2], calls_r[4] | calls_r[0]};
  assign car_up_s = {calls_r[6], calls_r[5] | calls_r[1], calls_r[4] | calls_r[0]};
  assign car_dn_s = {calls_r[6] | calls_r[3], calls_r[5] | calls_r[2], calls_r[4]};

  // Service clearing: hall calls against the travel direction survive while work remains beyond.
  always_comb begin
    clr_s      = 7'b0000000;
    above_fs_s = 1'b0;
    below_fs_s = 1'b0;
    case (FS)
      2'd1:    above_fs_s = dem_s[1] | dem_s[2];
      2'd2: begin
        above_fs_s = dem_s[2];
        below_fs_s = dem_s[0];
      end
      2'd3:    below_fs_s = dem_s[0] | dem_s[1];
      default: above_fs_s = 1'b0;
    endcase
    if (service_s) begin
      case (FS)
        2'd1: begin
          clr_s[4] = 1'b1;
          clr_s[0] = (state_r != ST_DOWN) | ~below_fs_s;
        end
        2'd2: begin
          clr_s[5] = 1'b1;
          clr_s[1] = (state_r != ST_DOWN) | ~below_fs_s;
          clr_s[2] = (state_r != ST_UP) | ~above_fs_s;
        end
        2'd3: begin
          clr_s[6] = 1'b1;
          clr_s[3] = (state_r != ST_UP) | ~above_fs_s;
        end
        default: clr_s = 7'b0000000;
      endcase
    end else begin
      clr_s = 7'b0000000;
    end
  end

  // Candidate targets above, below and nearest to the current floor.
  always_comb begin
    up_hit_s   = 1'b0;
    up_flr_s   = 2'd1;
    dn_hit_s   = 1'b0;
    dn_flr_s   = 2'd1;
    near_hit_s = 1'b1;
    near_flr_s = 2'd1;
    case (cur_floor_r)
      2'd1: begin
        up_hit_s = dem_s[1] | dem_s[2];
        up_flr_s = (car_up_s[1] | ~dem_s[2]) ? 2'd2 : 2'd3;
        if (dem_s[0])      near_flr_s = 2'd1;
        else if (dem_s[1]) near_flr_s = 2'd2;
        else if (dem_s[2]) near_flr_s = 2'd3;
        else               near_hit_s = 1'b0;
      end
      2'd2: begin
        up_hit_s = dem_s[2];
        up_flr_s = 2'd3;
        dn_hit_s = dem_s[0];
        dn_flr_s = 2'd1;
        if (dem_s[1])      near_flr_s = 2'd2;
        else if (dem_s[0]) near_flr_s = 2'd1;
        else if (dem_s[2]) near_flr_s = 2'd3;
        else               near_hit_s = 1'b0;
      end
      2'd3: begin
        dn_hit_s = dem_s[0] | dem_s[1];
        dn_flr_s = (car_dn_s[1] | ~dem_s[0]) ? 2'd2 : 2'd1;
        if (dem_s[2])      near_flr_s = 2'd3;
        else if (dem_s[1]) near_flr_s = 2'd2;
        else if (dem_s[0]) near_flr_s = 2'd1;
        else               near_hit_s = 1'b0;
      end
      default: near_hit_s = 1'b0;
    endcase
  end

  // Next state and target. With nothing ahead or behind, fall back to IDLE rules so demand
  // left only at the current floor parks the car instead of flipping direction each cycle.
  always_comb begin
    state_s    = state_r;
    valid_s    = 1'b0;
    floor_s    = tgt_floor;
    dir_s      = 2'b00;
    use_idle_s = 1'b0;
    case (state_r)
      ST_UP: begin
        if (up_hit_s) begin
          valid_s = 1'b1; floor_s = up_flr_s; dir_s = 2'b01; state_s = ST_UP;
        end else if (dn_hit_s) begin
          valid_s = 1'b1; floor_s = dn_flr_s; dir_s = 2'b10; state_s = ST_DOWN;
        end else begin
          use_idle_s = 1'b1;
        end
      end
      ST_DOWN: begin
        if (dn_hit_s) begin
          valid_s = 1'b1; floor_s = dn_flr_s; dir_s = 2'b10; state_s = ST_DOWN;
        end else if (up_hit_s) begin
          valid_s = 1'b1; floor_s = up_flr_s; dir_s = 2'b01; state_s = ST_UP;
        end else begin
          use_idle_s = 1'b1;
        end
      end
      default: use_idle_s = 1'b1;
    endcase
    if (use_idle_s) begin
      if (!near_hit_s) begin
        valid_s = 1'b0; dir_s = 2'b00; state_s = ST_IDLE;
      end else begin
        valid_s = 1'b1;
        floor_s = near_flr_s;
        if (near_flr_s > cur_floor_r) begin
          dir_s = 2'b01; state_s = ST_UP;
        end else if (near_flr_s < cur_floor_r) begin
          dir_s = 2'b10; state_s = ST_DOWN;
        end else begin
          dir_s = 2'b00; state_s = ST_IDLE;
        end
      end
    end else begin
      use_idle_s = 1'b0;
    end
  end

  // Call registers, position, door edge detector, FSM and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      calls_r     <= 7'b0000000;
      cur_floor_r <= 2'd1;
      door_q_r    <= 1'b0;
      state_r     <= ST_IDLE;
      tgt_valid   <= 1'b0;
      tgt_floor   <= 2'd1;
      tgt_dir     <= 2'b00;
    end else begin
      calls_r     <= (calls_r & ~clr_s) | btn_s;
      cur_floor_r <= (FS != 2'd0) ? FS : cur_floor_r;
      door_q_r    <= door;
      state_r     <= state_s;
      tgt_valid   <= valid_s;
      tgt_floor   <= floor_s;
      tgt_dir     <= dir_s;
    end
  end

  assign lamps = calls_r;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Scoreboard bench: the driver steps a floor-level reference model and queues the expected
// outputs; a monitor one delta after each clock edge pops and compares.
module tb_elevator_call_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       UP1 = 1'b0, UP2 = 1'b0, DOWN2 = 1'b0, DOWN3 = 1'b0;
  logic       FLOOR1 = 1'b0, FLOOR2 = 1'b0, FLOOR3 = 1'b0;
  logic [1:0] FS = 2'd1;
  logic       door = 1'b0;
  logic [6:0] lamps;
  logic       tgt_valid;
  logic [1:0] tgt_floor, tgt_dir;

  elevator_call_scheduler dut (
    .clk(clk), .rst(rst), .UP1(UP1), .UP2(UP2), .DOWN2(DOWN2), .DOWN3(DOWN3),
    .FLOOR1(FLOOR1), .FLOOR2(FLOOR2), .FLOOR3(FLOOR3), .FS(FS), .door(door),
    .lamps(lamps), .tgt_valid(tgt_valid), .tgt_floor(tgt_floor), .tgt_dir(tgt_dir)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] lamps;
    logic       v;
    logic [1:0] fl;
    logic [1:0] dir;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: calls as a lamp vector, state 0 idle / 1 up / 2 down.
  logic [6:0] m_calls;
  int         m_state, m_cur, m_floor, m_dir;
  bit         m_dq, m_valid;

  function automatic void chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endfunction

  function automatic int car_bit(int f); return 3 + f; endfunction
  function automatic int up_bit(int f);  return (f == 1) ? 0 : (f == 2) ? 1 : -1; endfunction
  function automatic int dn_bit(int f);  return (f == 2) ? 2 : (f == 3) ? 3 : -1; endfunction

  function automatic bit has(logic [6:0] c, int b);
    return (b >= 0) ? c[b] : 1'b0;
  endfunction

  function automatic bit dem(logic [6:0] c, int f);
    return has(c, car_bit(f)) | has(c, up_bit(f)) | has(c, dn_bit(f));
  endfunction

  function automatic void plan(input logic [6:0] c, input int cur, input int st,
                               output int ns, output bit v, output int fl, output int dir);
    int a, b, n;
    a = 0; b = 0; n = 0;
    for (int f = cur + 1; f <= 3; f++)
      if (a == 0 && (has(c, car_bit(f)) || has(c, up_bit(f)))) a = f;
    for (int f = 3; f > cur; f--)
      if (a == 0 && dem(c, f)) a = f;
    for (int f = cur - 1; f >= 1; f--)
      if (b == 0 && (has(c, car_bit(f)) || has(c, dn_bit(f)))) b = f;
    for (int f = 1; f < cur; f++)
      if (b == 0 && dem(c, f)) b = f;
    for (int d = 0; d <= 2; d++)
      for (int f = 1; f <= 3; f++)
        if (n == 0 && dem(c, f) && (f - cur == d || cur - f == d)) n = f;
    v = 1'b1; fl = 0; ns = 0; dir = 0;
    if (st == 1 && a != 0)      begin ns = 1; fl = a; dir = 1; end
    else if (st == 1 && b != 0) begin ns = 2; fl = b; dir = 2; end
    else if (st == 2 && b != 0) begin ns = 2; fl = b; dir = 2; end
    else if (st == 2 && a != 0) begin ns = 1; fl = a; dir = 1; end
    else if (n == 0)            begin ns = 0; v = 1'b0; dir = 0; end
    else begin
      fl = n;
      if (n > cur)      begin ns = 1; dir = 1; end
      else if (n < cur) begin ns = 2; dir = 2; end
      else              begin ns = 0; dir = 0; end
    end
  endfunction

  task automatic model_step(input logic [6:0] b, input int fs, input bit d, input bit r);
    int ns, fl, dir;
    bit v, beyond;
    logic [6:0] clr;
    if (!r) begin
      m_calls = 7'd0; m_state = 0; m_cur = 1; m_dq = 1'b0;
      m_valid = 1'b0; m_floor = 1; m_dir = 0;
    end else begin
      plan(m_calls, m_cur, m_state, ns, v, fl, dir);
      clr = 7'd0;
      if (d && !m_dq && fs != 0) begin
        clr[car_bit(fs)] = 1'b1;
        beyond = 1'b0;
        for (int f = fs + 1; f <= 3; f++) if (dem(m_calls, f)) beyond = 1'b1;
        if (dn_bit(fs) >= 0 && (m_state != 1 || !beyond)) clr[dn_bit(fs)] = 1'b1;
        beyond = 1'b0;
        for (int f = 1; f < fs; f++) if (dem(m_calls, f)) beyond = 1'b1;
        if (up_bit(fs) >= 0 && (m_state != 2 || !beyond)) clr[up_bit(fs)] = 1'b1;
      end
      m_calls = (m_calls & ~clr) | b;
      if (fs != 0) m_cur = fs;
      m_dq    = d;
      m_state = ns;
      m_valid = v;
      if (v) m_floor = fl;
      m_dir = dir;
    end
  endtask

  // One cycle of stimulus, issued from a falling edge; queues what the next rising edge yields.
  task automatic cyc(input logic [6:0] b, input logic [1:0] fs, input logic d, input logic r);
    exp_t e;
    {FLOOR3, FLOOR2, FLOOR1, DOWN3, DOWN2, UP2, UP1} = b;
    FS   = fs;
    door = d;
    if (!r && rst) begin
      rst = 1'b0;
      #1;
      chk("async_lamps", {1'b0, lamps}, 8'h00);
      chk("async_valid", {7'd0, tgt_valid}, 8'h00);
      chk("async_dir", {6'd0, tgt_dir}, 8'h00);
      chk("async_floor", {6'd0, tgt_floor}, 8'h01);
    end else begin
      rst = r;
    end
    model_step(b, int'(fs), d, r);
    e.lamps = m_calls; e.v = m_valid; e.fl = m_floor[1:0]; e.dir = m_dir[1:0];
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n, input logic [1:0] fs);
    for (int i = 0; i < n; i++) cyc(7'd0, fs, 1'b0, 1'b1);
  endtask

  // Monitor: the DUT presents a fresh output set after every rising edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("lamps", {1'b0, lamps}, {1'b0, e.lamps});
      chk("tgt_valid", {7'd0, tgt_valid}, {7'd0, e.v});
      chk("tgt_dir", {6'd0, tgt_dir}, {6'd0, e.dir});
      if (e.v) chk("tgt_floor", {6'd0, tgt_floor}, {6'd0, e.fl});
    end
  end

  initial begin
    logic [6:0] b;
    logic [1:0] fs;
    logic       d;
    #1;
    cyc(7'd0, 2'd1, 1'b0, 1'b0);
    cyc(7'd0, 2'd1, 1'b0, 1'b0);
    // FLOOR3 pulse from floor 1
    cyc(7'b1000000, 2'd1, 1'b0, 1'b1);
    idle_cycles(3, 2'd1);
    // UP2 ahead preempts, then service at 2 clears only UP2
    cyc(7'b0000010, 2'd1, 1'b0, 1'b1);
    idle_cycles(3, 2'd1);
    idle_cycles(2, 2'd0);
    cyc(7'd0, 2'd2, 1'b1, 1'b1);
    idle_cycles(3, 2'd2);
    idle_cycles(2, 2'd0);
    cyc(7'd0, 2'd3, 1'b1, 1'b1);
    idle_cycles(3, 2'd3);
    // reset while calls are pending
    cyc(7'b0010001, 2'd3, 1'b0, 1'b1);
    idle_cycles(2, 2'd3);
    cyc(7'd0, 2'd0, 1'b0, 1'b0);
    cyc(7'd0, 2'd1, 1'b0, 1'b0);
    // FLOOR3 + DOWN2 from floor 1: DOWN2 passed going up, served on the way down
    cyc(7'b1000100, 2'd1, 1'b0, 1'b1);
    idle_cycles(4, 2'd1);
    idle_cycles(2, 2'd0);
    cyc(7'd0, 2'd3, 1'b1, 1'b1);
    idle_cycles(4, 2'd3);
    cyc(7'd0, 2'd2, 1'b1, 1'b1);
    idle_cycles(4, 2'd2);
    // idle at 2, equidistant calls resolve low
    cyc(7'b0001001, 2'd2, 1'b0, 1'b1);
    idle_cycles(3, 2'd2);
    // FLOOR2 pressed on the service edge stays latched
    cyc(7'b0100000, 2'd2, 1'b0, 1'b1);
    idle_cycles(2, 2'd2);
    cyc(7'b0100000, 2'd2, 1'b1, 1'b1);
    idle_cycles(3, 2'd2);
    // randomized traffic
    fs = 2'd2; d = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      b = 7'd0;
      for (int i = 0; i < 7; i++) if ($urandom_range(15) == 0) b[i] = 1'b1;
      if ($urandom_range(3) == 0) fs = 2'($urandom_range(3));
      if ($urandom_range(2) == 0) d = ~d;
      cyc(b, fs, d, ($urandom_range(499) == 0) ? 1'b0 : 1'b1);
    end
    idle_cycles(2, fs);
    chk("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
